fetch_queue: RTL and testbench

//   Instruction queue between Fetch and Decode; decouples the fetch clock domain phase from decode stalls.

---
 rtl/fetch_queue.sv | 74 +++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// In-order {pc, instruction} queue between Fetch and Decode with valid/ready on both sides and a flush.
// Define FETCH_QUEUE_NOP_FILL_EN to present a NOP with pc=0 at the head whenever the queue is empty.
module fetch_queue #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD-1:0]            in_pc,
    input  logic [INSTR_LEN-1:0]       in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD-1:0]            out_pc,
    output logic [INSTR_LEN-1:0]       out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WORD-1:0]      pc_mem    [DEPTH];
    logic [INSTR_LEN-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Reset outranks flush, and flush discards any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

`ifdef FETCH_QUEUE_NOP_FILL_EN
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : INSTR_LEN'(32'hD503201F);
`else
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written wrap sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;
    localparam int DEPTH     = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WORD-1:0]        in_pc = '0;
    logic [INSTR_LEN-1:0]   in_instr = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [WORD-1:0]        out_pc;
    logic [INSTR_LEN-1:0]   out_instr;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.WORD(WORD), .INSTR_LEN(INSTR_LEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [63:0] pc;
        int          exp_count;
        logic        exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: the queue contents in order, each entry {pc, instr}.
    logic [WORD+INSTR_LEN-1:0] model_q[$];

    function automatic logic [INSTR_LEN-1:0] mk_instr(input logic [63:0] pc);
        return 32'hA000_0000 ^ pc[31:0];
    endfunction

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv, input logic ordy,
                                input logic [63:0] pc, input int ec, input logic ev, input logic [63:0] epc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc;
        v.exp_count = ec; v.exp_valid = ev; v.exp_pc = epc;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [WORD+INSTR_LEN-1:0] head;
        cmp({tag, " count"}, 64'(count), 64'(model_q.size()));
        cmp({tag, " out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
        cmp({tag, " in_ready"}, 64'(in_ready), 64'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
            head = model_q[0];
            cmp({tag, " out_pc"}, out_pc, head[WORD+INSTR_LEN-1:INSTR_LEN]);
            cmp({tag, " out_instr"}, 64'(out_instr), 64'(head[INSTR_LEN-1:0]));
        end
`ifdef FETCH_QUEUE_NOP_FILL_EN
        else begin
            cmp({tag, " nop out_pc"}, out_pc, 64'd0);
            cmp({tag, " nop out_instr"}, 64'(out_instr), 64'h0000_0000_D503_201F);
        end
`endif
    endtask

    // Drive one cycle, advance the model by the queue's rules, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv, input logic ordy,
                                 input logic [63:0] pc, input logic [INSTR_LEN-1:0] instr);
        logic can_push;
        logic can_pop;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = pc;
        in_instr  = instr;
        can_push  = iv && (model_q.size() < DEPTH);
        can_pop   = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (can_pop)  void'(model_q.pop_front());
            if (can_push) model_q.push_back({pc, instr});
        end
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        // Reset, fill, full stall, drain, idle pop, flush, reset-vs-flush, reset mid-drain.
        vecs.push_back(mk(1, 0, 0, 0, 64'd0,   0, 0, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd0,   1, 1, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd4,   2, 1, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd8,   3, 1, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd12,  4, 1, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd16,  4, 1, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd16,  4, 1, 64'd0));
        vecs.push_back(mk(0, 0, 1, 1, 64'd16,  3, 1, 64'd4));
        vecs.push_back(mk(0, 0, 1, 0, 64'd16,  4, 1, 64'd4));
        vecs.push_back(mk(0, 0, 0, 1, 64'd0,   3, 1, 64'd8));
        vecs.push_back(mk(0, 0, 0, 1, 64'd0,   2, 1, 64'd12));
        vecs.push_back(mk(0, 0, 0, 1, 64'd0,   1, 1, 64'd16));
        vecs.push_back(mk(0, 0, 0, 1, 64'd0,   0, 0, 64'd0));
        vecs.push_back(mk(0, 0, 0, 1, 64'd0,   0, 0, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd40,  1, 1, 64'd40));
        vecs.push_back(mk(0, 0, 1, 0, 64'd44,  2, 1, 64'd40));
        vecs.push_back(mk(0, 0, 1, 0, 64'd48,  3, 1, 64'd40));
        vecs.push_back(mk(0, 1, 1, 1, 64'd100, 0, 0, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd200, 1, 1, 64'd200));
        vecs.push_back(mk(0, 0, 1, 0, 64'd204, 2, 1, 64'd200));
        vecs.push_back(mk(1, 1, 1, 0, 64'd300, 0, 0, 64'd0));
        vecs.push_back(mk(0, 0, 1, 0, 64'h10,  1, 1, 64'h10));
        vecs.push_back(mk(0, 0, 1, 0, 64'h14,  2, 1, 64'h10));
        vecs.push_back(mk(0, 0, 0, 1, 64'd0,   1, 1, 64'h14));
        vecs.push_back(mk(1, 0, 1, 1, 64'h18,  0, 0, 64'd0));
        vecs.push_back(mk(0, 0, 0, 0, 64'd0,   0, 0, 64'd0));

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].pc, mk_instr(vecs[i].pc));
            cmp($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].exp_count));
            cmp($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                cmp($sformatf("vec%0d out_pc", i), out_pc, vecs[i].exp_pc);
                cmp($sformatf("vec%0d out_instr", i), 64'(out_instr), 64'(mk_instr(vecs[i].exp_pc)));
            end
            checkOutput($sformatf("vec%0d model", i));
        end

        // Concurrent push/pop at count=2 across several pointer wraps.
        applyStimulus(0, 0, 1, 0, 64'h1000, mk_instr(64'h1000));
        applyStimulus(0, 0, 1, 0, 64'h1004, mk_instr(64'h1004));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 1, 64'h1008 + 64'(4 * i), mk_instr(64'h1008 + 64'(4 * i)));
            cmp($sformatf("conc%0d count", i), 64'(count), 64'd2);
            cmp($sformatf("conc%0d out_pc", i), out_pc, 64'h1000 + 64'(4 * (i + 1)));
            checkOutput($sformatf("conc%0d model", i));
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [63:0] rpc;
            rpc = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                          rpc, 32'($urandom));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
